udp_tx_header_serializer: RTL and testbench

Transmit-side counterpart of the UDP RX header path. It accepts one UDP header descriptor from user logic plus a byte-wide payload stream, and emits a complete Ethernet/IPv4/UDP frame (42 header bytes, then payload) on a byte-wide AXI-Stream toward the MAC. It fills in the fixed fields and the IPv4 total length, and computes the IPv4 header checksum.

---
 rtl/udp_tx_header_serializer.sv | 224 ++++++++++++++++++++++
 tb/tb_udp_tx_header_serializer.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_tx_header_serializer.sv
// udp_tx_header_serializer
//
// Purpose: takes one UDP header descriptor and a byte-wide payload stream and
// emits a complete Ethernet/IPv4/UDP frame on a byte-wide AXI-Stream. The
// frame is 42 header bytes followed by the payload. The block fills in the
// fixed fields (eth_type 0x0800, version 4, IHL 5, protocol 17) and the IPv4
// total length (UDP length + 20, wrapping at 16 bits). It can also compute the
// IPv4 header checksum.
//
// Build option: define UDP_TX_HDR_IP_CSUM_EN to compute the IPv4 header
// checksum. This costs 10 extra cycles between accept and byte 0, and the
// ip_header_checksum input is then ignored. When the macro is undefined, bytes
// 24-25 carry the captured ip_header_checksum as given, and byte 0 follows
// accept by one cycle.
//
// Ports:
//   clk, sreset_n        : clock, synchronous active-low reset
//   hdr_valid/hdr_ready  : descriptor handshake (hdr_ready is registered)
//   eth_*, ip_*, source_port, dest_port, length, checksum : descriptor fields
//   s_axis_*             : payload input (8-bit)
//   m_axis_*             : frame output (8-bit)
module udp_tx_header_serializer (
  input  logic        clk,
  input  logic        sreset_n,
  input  logic        hdr_valid,
  output logic        hdr_ready,
  input  logic [47:0] eth_dest_mac,
  input  logic [47:0] eth_src_mac,
  input  logic [5:0]  ip_dscp,
  input  logic [1:0]  ip_ecn,
  input  logic [15:0] ip_identification,
  input  logic [2:0]  ip_flags,
  input  logic [12:0] ip_fragment_offset,
  input  logic [7:0]  ip_ttl,
  input  logic [15:0] ip_header_checksum,
  input  logic [31:0] ip_source_ip,
  input  logic [31:0] ip_dest_ip,
  input  logic [15:0] source_port,
  input  logic [15:0] dest_port,
  input  logic [15:0] length,
  input  logic [15:0] checksum,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CSUM    = 2'd1;
  localparam logic [1:0] ST_HDR     = 2'd2;
  localparam logic [1:0] ST_PAYLOAD = 2'd3;

  typedef struct packed {
    logic [47:0] dest_mac;
    logic [47:0] src_mac;
    logic [5:0]  dscp;
    logic [1:0]  ecn;
    logic [15:0] ident;
    logic [2:0]  flags;
    logic [12:0] frag;
    logic [7:0]  ttl;
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [15:0] udp_len;
    logic [15:0] udp_csum;
  } desc_t;

  logic [1:0]  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;      // CSUM word index, then header byte index
  logic [19:0] acc_q, acc_d;
  logic [15:0] csum_q, csum_d;
  logic        hdr_ready_q;
  desc_t       desc_q, desc_d, desc_in;

  logic [15:0]  total_len;
  logic         short_frame;
  logic [15:0]  csum_word;
  logic [19:0]  acc_sum;
  logic [19:0]  fold1;
  logic [15:0]  fold2;
  logic [335:0] hdr_vec;
  logic [7:0]   hdr_bytes [0:41];

`ifdef UDP_TX_HDR_IP_CSUM_EN
  logic unused_hdr_csum_in;
  assign unused_hdr_csum_in = ^ip_header_checksum;
`endif

  assign desc_in = '{
    dest_mac: eth_dest_mac, src_mac: eth_src_mac, dscp: ip_dscp, ecn: ip_ecn,
    ident: ip_identification, flags: ip_flags, frag: ip_fragment_offset,
    ttl: ip_ttl, src_ip: ip_source_ip, dst_ip: ip_dest_ip,
    src_port: source_port, dst_port: dest_port, udp_len: length,
    udp_csum: checksum
  };

  assign total_len   = desc_q.udp_len + 16'd20;
  // A UDP length of 8 or less means a header-only frame: tlast on byte 41.
  assign short_frame = (desc_q.udp_len <= 16'd8);
  assign hdr_ready   = hdr_ready_q;

  // Whole header as one MSB-first vector; byte n sits at bits (41-n)*8.
  assign hdr_vec = {desc_q.dest_mac, desc_q.src_mac, 16'h0800, 8'h45,
                    desc_q.dscp, desc_q.ecn, total_len, desc_q.ident,
                    desc_q.flags, desc_q.frag, desc_q.ttl, 8'd17, csum_q,
                    desc_q.src_ip, desc_q.dst_ip, desc_q.src_port,
                    desc_q.dst_port, desc_q.udp_len, desc_q.udp_csum};

  generate
    for (genvar gi = 0; gi < 42; gi++) begin : g_hdr_byte
      assign hdr_bytes[gi] = hdr_vec[(41-gi)*8 +: 8];
    end
  endgenerate

  // IPv4 header words, one per CSUM cycle; the checksum word itself is 0.
  always_comb begin
    csum_word = 16'h0000;
    case (cnt_q[3:0])
      4'd0:    csum_word = {8'h45, desc_q.dscp, desc_q.ecn};
      4'd1:    csum_word = total_len;
      4'd2:    csum_word = desc_q.ident;
      4'd3:    csum_word = {desc_q.flags, desc_q.frag};
      4'd4:    csum_word = {desc_q.ttl, 8'd17};
      4'd6:    csum_word = desc_q.src_ip[31:16];
      4'd7:    csum_word = desc_q.src_ip[15:0];
      4'd8:    csum_word = desc_q.dst_ip[31:16];
      4'd9:    csum_word = desc_q.dst_ip[15:0];
      default: csum_word = 16'h0000;
    endcase
  end

  // Ten 16-bit words fit in 20 bits. Two folds absorb every carry.
  assign acc_sum = acc_q + {4'h0, csum_word};
  assign fold1   = {4'h0, acc_sum[15:0]} + {16'h0000, acc_sum[19:16]};
  assign fold2   = fold1[15:0] + {12'h000, fold1[19:16]};

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    acc_d         = acc_q;
    csum_d        = csum_q;
    desc_d        = desc_q;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = 8'h00;
    m_axis_tlast  = 1'b0;
    s_axis_tready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (hdr_valid && hdr_ready_q) begin
          desc_d = desc_in;
          cnt_d  = 6'd0;
          acc_d  = 20'h00000;
`ifdef UDP_TX_HDR_IP_CSUM_EN
          state_d = ST_CSUM;
`else
          csum_d  = ip_header_checksum;
          state_d = ST_HDR;
`endif
        end
      end
      ST_CSUM: begin
        acc_d = acc_sum;
        if (cnt_q == 6'd9) begin
          cnt_d   = 6'd0;
          csum_d  = ~fold2;
          state_d = ST_HDR;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      ST_HDR: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = hdr_bytes[cnt_q];
        m_axis_tlast  = short_frame && (cnt_q == 6'd41);
        if (m_axis_tready) begin
          if (cnt_q == 6'd41) begin
            cnt_d   = 6'd0;
            state_d = short_frame ? ST_IDLE : ST_PAYLOAD;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      ST_PAYLOAD: begin
        m_axis_tvalid = s_axis_tvalid;
        m_axis_tdata  = s_axis_tdata;
        m_axis_tlast  = s_axis_tlast;
        s_axis_tready = m_axis_tready;
        if (s_axis_tvalid && m_axis_tready && s_axis_tlast) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!sreset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 6'd0;
      acc_q       <= 20'h00000;
      csum_q      <= 16'h0000;
      hdr_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      csum_q      <= csum_d;
      hdr_ready_q <= (state_d == ST_IDLE);
    end
  end

  // Descriptor copy only changes on accept and needs no reset.
  always_ff @(posedge clk) begin
    desc_q <= desc_d;
  end

endmodule

// File: tb/tb_udp_tx_header_serializer.sv
// Testbench for udp_tx_header_serializer. Randomised and directed frames are
// scored against a reference frame builder. Follows UDP_TX_HDR_IP_CSUM_EN
// the same way the design does.
module tb_udp_tx_header_serializer;

`ifdef UDP_TX_HDR_IP_CSUM_EN
  localparam int LAT = 11;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        sreset_n, hdr_valid, hdr_ready;
  logic [47:0] eth_dest_mac, eth_src_mac;
  logic [5:0]  ip_dscp;
  logic [1:0]  ip_ecn;
  logic [15:0] ip_identification, ip_header_checksum;
  logic [2:0]  ip_flags;
  logic [12:0] ip_fragment_offset;
  logic [7:0]  ip_ttl;
  logic [31:0] ip_source_ip, ip_dest_ip;
  logic [15:0] source_port, dest_port, length, checksum;
  logic [7:0]  s_axis_tdata, m_axis_tdata;
  logic        s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;

  udp_tx_header_serializer dut (
    .clk(clk), .sreset_n(sreset_n), .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
    .eth_dest_mac(eth_dest_mac), .eth_src_mac(eth_src_mac),
    .ip_dscp(ip_dscp), .ip_ecn(ip_ecn), .ip_identification(ip_identification),
    .ip_flags(ip_flags), .ip_fragment_offset(ip_fragment_offset), .ip_ttl(ip_ttl),
    .ip_header_checksum(ip_header_checksum), .ip_source_ip(ip_source_ip),
    .ip_dest_ip(ip_dest_ip), .source_port(source_port), .dest_port(dest_port),
    .length(length), .checksum(checksum),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast)
  );

  typedef struct packed {
    logic [47:0] dmac, smac;
    logic [5:0]  dscp;
    logic [1:0]  ecn;
    logic [15:0] id;
    logic [2:0]  flags;
    logic [12:0] frag;
    logic [7:0]  ttl;
    logic [15:0] hcs;
    logic [31:0] sip, dip;
    logic [15:0] sport, dport, len, ucs;
  } desc_t;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } xbyte_t;

  xbyte_t     exp_q[$];
  xbyte_t     pay_q[$];
  logic [7:0] obs_q[$];
  logic [7:0] pay_buf[16];
  int         pay_n = 0;
  int         checks = 0;
  int         failures = 0;
  int         rdy_mode = 0;
  bit         mon_en = 1'b1;
  int         sready_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: ones-complement sum over the ten header words, carries folded
  // back in until nothing is left above bit 15.
  function automatic logic [15:0] ip_csum(input desc_t d);
    logic [15:0] w [10];
    logic [15:0] tl;
    int unsigned s;
    tl = d.len + 16'd20;
    w[0] = {8'h45, d.dscp, d.ecn};
    w[1] = tl;
    w[2] = d.id;
    w[3] = {d.flags, d.frag};
    w[4] = {d.ttl, 8'd17};
    w[5] = 16'h0000;
    w[6] = d.sip[31:16];
    w[7] = d.sip[15:0];
    w[8] = d.dip[31:16];
    w[9] = d.dip[15:0];
    s = 0;
    for (int i = 0; i < 10; i++) s += 32'(w[i]);
    while (s > 32'h0000FFFF) s = (s & 32'h0000FFFF) + (s >> 16);
    return ~s[15:0];
  endfunction

  function automatic void put(input logic [63:0] v, input int n);
    xbyte_t x;
    for (int i = n - 1; i >= 0; i--) begin
      x.d = v[8*i +: 8];
      x.l = 1'b0;
      exp_q.push_back(x);
    end
  endfunction

  function automatic void build_expected(input desc_t d);
    logic [15:0] tl, cs;
    xbyte_t x;
    tl = d.len + 16'd20;
`ifdef UDP_TX_HDR_IP_CSUM_EN
    cs = ip_csum(d);
`else
    cs = d.hcs;
`endif
    put(64'(d.dmac), 6); put(64'(d.smac), 6); put(64'h0800, 2);
    put(64'h45, 1); put(64'({d.dscp, d.ecn}), 1); put(64'(tl), 2);
    put(64'(d.id), 2); put(64'({d.flags, d.frag}), 2); put(64'(d.ttl), 1);
    put(64'd17, 1); put(64'(cs), 2); put(64'(d.sip), 4); put(64'(d.dip), 4);
    put(64'(d.sport), 2); put(64'(d.dport), 2); put(64'(d.len), 2);
    put(64'(d.ucs), 2);
    if (d.len <= 16'd8) begin
      x = exp_q.pop_back();
      x.l = 1'b1;
      exp_q.push_back(x);
    end else begin
      for (int i = 0; i < pay_n; i++) begin
        x.d = pay_buf[i];
        x.l = (i == pay_n - 1);
        exp_q.push_back(x);
        pay_q.push_back(x);
      end
    end
  endfunction

  function automatic desc_t rand_desc();
    desc_t d;
    logic [63:0] r;
    r = {$urandom(), $urandom()}; d.dmac = r[47:0];
    r = {$urandom(), $urandom()}; d.smac = r[47:0];
    r = {$urandom(), $urandom()};
    d.dscp = r[5:0]; d.ecn = r[7:6]; d.id = r[23:8]; d.flags = r[26:24];
    d.frag = r[39:27]; d.ttl = r[47:40]; d.hcs = r[63:48];
    d.sip = $urandom(); d.dip = $urandom();
    r = {$urandom(), $urandom()};
    d.sport = r[15:0]; d.dport = r[31:16]; d.ucs = r[47:32];
    d.len = 16'($urandom_range(9, 1500));
    return d;
  endfunction

  task automatic apply_desc(input desc_t d);
    eth_dest_mac = d.dmac; eth_src_mac = d.smac; ip_dscp = d.dscp; ip_ecn = d.ecn;
    ip_identification = d.id; ip_flags = d.flags; ip_fragment_offset = d.frag;
    ip_ttl = d.ttl; ip_header_checksum = d.hcs; ip_source_ip = d.sip;
    ip_dest_ip = d.dip; source_port = d.sport; dest_port = d.dport;
    length = d.len; checksum = d.ucs;
  endtask

  // Drives one descriptor. Checks accept, latency to byte 0, frame completion
  // and hdr_ready in the cycle after the final transfer.
  task automatic drive_frame(input desc_t d, input string tag);
    bit ok;
    int n;
    obs_q.delete();
    build_expected(d);
    @(posedge clk); #1;
    apply_desc(d);
    hdr_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (hdr_ready) begin ok = 1'b1; break; end
    end
    chk({tag, "_accept"}, 32'(ok), 32'd1);
    if (!ok) begin
      hdr_valid = 1'b0; exp_q.delete(); pay_q.delete();
      return;
    end
    @(posedge clk); #1;
    hdr_valid = 1'b0;
    apply_desc(rand_desc());
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (m_axis_tvalid) begin n = i; break; end
    end
    chk({tag, "_latency"}, 32'(n), 32'(LAT));
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      if (exp_q.size() == 0) begin ok = 1'b1; break; end
      @(negedge clk); #2;
    end
    chk({tag, "_complete"}, 32'(ok), 32'd1);
    if (!ok) begin exp_q.delete(); pay_q.delete(); end
    @(negedge clk);
    chk({tag, "_hdr_ready_after"}, 32'(hdr_ready), 32'd1);
    $display("frame %s len=%0d payload=%0d bytes_seen=%0d", tag, d.len, pay_n, obs_q.size());
  endtask

  // Output ready pattern: 0 = always ready, 1 = toggle, 2 = random.
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = ~m_axis_tready;
        default: m_axis_tready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Payload source: presents the head of pay_q and holds it until taken.
  initial begin
    bit fire;
    s_axis_tvalid = 1'b0; s_axis_tdata = 8'h00; s_axis_tlast = 1'b0;
    forever begin
      @(negedge clk);
      fire = s_axis_tvalid && s_axis_tready;
      @(posedge clk); #1;
      if (fire && pay_q.size() > 0) void'(pay_q.pop_front());
      if (pay_q.size() > 0) begin
        s_axis_tdata = pay_q[0].d; s_axis_tlast = pay_q[0].l; s_axis_tvalid = 1'b1;
      end else begin
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
      end
    end
  end

  // Monitor: pops and compares on every output transfer; checks held data
  // across stalls.
  initial begin
    xbyte_t     e;
    logic [7:0] sd;
    logic       sl;
    bit         hs;
    int         fb;
    hs = 1'b0; fb = 0; sd = 8'h00; sl = 1'b0;
    forever begin
      @(negedge clk);
      if (s_axis_tready) sready_seen++;
      if (!mon_en || !sreset_n) begin hs = 1'b0; fb = 0; continue; end
      if (hs) begin
        checks++;
        if (!m_axis_tvalid || m_axis_tdata !== sd || m_axis_tlast !== sl) begin
          failures++;
          $display("FAIL stall_hold byte%0d actual=%h/%b/v%b required=%h/%b/v1",
                   fb, m_axis_tdata, m_axis_tlast, m_axis_tvalid, sd, sl);
        end
      end
      hs = 1'b0;
      if (m_axis_tvalid && m_axis_tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_byte actual=%h required=none", m_axis_tdata);
        end else begin
          e = exp_q.pop_front();
          if (m_axis_tdata !== e.d || m_axis_tlast !== e.l) begin
            failures++;
            $display("FAIL byte%0d actual=%h/last%b required=%h/last%b",
                     fb, m_axis_tdata, m_axis_tlast, e.d, e.l);
          end
          obs_q.push_back(m_axis_tdata);
          fb = e.l ? 0 : fb + 1;
        end
      end else if (m_axis_tvalid) begin
        hs = 1'b1; sd = m_axis_tdata; sl = m_axis_tlast;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_hdr_ready"}, 32'(hdr_ready), 32'd0);
    chk({tag, "_m_tvalid"}, 32'(m_axis_tvalid), 32'd0);
    chk({tag, "_m_tlast"}, 32'(m_axis_tlast), 32'd0);
    chk({tag, "_s_tready"}, 32'(s_axis_tready), 32'd0);
    chk({tag, "_m_tdata"}, 32'(m_axis_tdata), 32'd0);
  endtask

  initial begin
    desc_t d, dfull;
    logic [7:0] ip_ref [20];
    logic [7:0] b20;
    bit ok;
    ip_ref = '{8'h45, 8'h00, 8'h00, 8'h73, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
               8'hB8, 8'h61, 8'hC0, 8'hA8, 8'h00, 8'h01, 8'hC0, 8'hA8, 8'h00, 8'hC7};
    sreset_n = 1'b0; hdr_valid = 1'b0;
    apply_desc(rand_desc());
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_outputs_zero("reset");
    @(posedge clk); #1;
    sreset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("reset_release_hdr_ready", 32'(hdr_ready), 32'd1);

    // Checksum vector.
    d = rand_desc();
    d.dscp = 6'd0; d.ecn = 2'd0; d.len = 16'h005F; d.id = 16'h0000; d.flags = 3'd2;
    d.frag = 13'd0; d.ttl = 8'h40; d.sip = 32'hC0A80001; d.dip = 32'hC0A800C7;
    d.hcs = 16'h1234;
    pay_n = 3;
    for (int i = 0; i < 3; i++) pay_buf[i] = 8'($urandom());
    drive_frame(d, "csum_vector");
`ifdef UDP_TX_HDR_IP_CSUM_EN
    for (int i = 0; i < 20; i++)
      chk($sformatf("csum_vector_ip_byte%0d", 14 + i),
          32'((obs_q.size() > 14 + i) ? obs_q[14 + i] : 8'hXX), 32'(ip_ref[i]));
`else
    chk("raw_csum_byte24", 32'((obs_q.size() > 24) ? obs_q[24] : 8'hXX), 32'h12);
    chk("raw_csum_byte25", 32'((obs_q.size() > 25) ? obs_q[25] : 8'hXX), 32'h34);
`endif

    // Full frame, 4-byte payload, ready tied high.
    dfull = rand_desc();
    dfull.len = 16'd12;
    pay_n = 4;
    pay_buf[0] = 8'hAA; pay_buf[1] = 8'hBB; pay_buf[2] = 8'hCC; pay_buf[3] = 8'hDD;
    rdy_mode = 0;
    drive_frame(dfull, "full_frame");
    chk("full_frame_count", 32'(obs_q.size()), 32'd46);
    chk("full_frame_byte12", 32'((obs_q.size() > 13) ? obs_q[12] : 8'hXX), 32'h08);
    chk("full_frame_byte13", 32'((obs_q.size() > 13) ? obs_q[13] : 8'hXX), 32'h00);

    // Same frame with ready toggling every cycle.
    rdy_mode = 1;
    drive_frame(dfull, "backpressure");
    chk("backpressure_count", 32'(obs_q.size()), 32'd46);

    // Header-only frame.
    rdy_mode = 0;
    d = rand_desc();
    d.len = 16'd8;
    pay_n = 0;
    sready_seen = 0;
    drive_frame(d, "len8");
    chk("len8_s_tready_never", 32'(sready_seen), 32'd0);
    chk("len8_count", 32'(obs_q.size()), 32'd42);

    // Reset during the header.
    mon_en = 1'b0;
    d = rand_desc();
    d.len = 16'd100;
    pay_n = 0;
    build_expected(d);
    b20 = exp_q[20].d;
    exp_q.delete();
    @(posedge clk); #1;
    apply_desc(d);
    hdr_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (hdr_ready) begin ok = 1'b1; break; end
    end
    chk("rst_mid_accept", 32'(ok), 32'd1);
    @(posedge clk); #1;
    hdr_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (m_axis_tvalid) begin ok = 1'b1; break; end
    end
    chk("rst_mid_byte0_seen", 32'(ok), 32'd1);
    repeat (20) @(negedge clk);
    chk("rst_mid_byte20", 32'(m_axis_tdata), 32'(b20));
    sreset_n = 1'b0;
    @(posedge clk); #1;
    sreset_n = 1'b1;
    @(negedge clk);
    chk_outputs_zero("rst_mid");
    @(negedge clk);
    chk("rst_mid_hdr_ready_after_release", 32'(hdr_ready), 32'd1);
    mon_en = 1'b1;
    d = rand_desc();
    pay_n = 2; pay_buf[0] = 8'h5A; pay_buf[1] = 8'hA5;
    drive_frame(d, "after_reset");

    // Random frames under random backpressure.
    rdy_mode = 2;
    for (int f = 0; f < 25; f++) begin
      d = rand_desc();
      case ($urandom_range(0, 3))
        0:       d.len = 16'($urandom_range(0, 8));
        1:       d.len = 16'hFFEC + 16'($urandom_range(0, 19));
        default: d.len = 16'($urandom_range(9, 1500));
      endcase
      pay_n = (d.len <= 16'd8) ? 0 : int'($urandom_range(1, 8));
      for (int i = 0; i < pay_n; i++) pay_buf[i] = 8'($urandom());
      drive_frame(d, $sformatf("rand%0d", f));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
